mem_stage: RTL and testbench

Memory-access pipeline stage between the execute stage and the write-back stage. It registers one instruction from execute and, if that instruction issued a data-SRAM request, waits for the bus `data_ok` response. If write-back is not ready, it holds the returned read data in a one-entry buffer. It then presents the instruction, its raw read word and its load control to write-back, and exports forwarding and load-use hazard information to decode.

---
 rtl/mem_stage.sv | 179 +++++++++++++++++
 tb/tb_mem_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Purpose:
//   Memory-access pipeline stage sitting between execute and write-back.
//   It holds one instruction. If that instruction issued a data-SRAM request,
//   the stage waits for the bus data_ok response. When write-back is stalled
//   at the moment data_ok arrives, the read word is kept in a one-entry
//   buffer. The stage also exports forwarding and load-use hazard
//   information to decode.
//
// State table:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_EMPTY | no instruction held
//   ST_WAIT  | instruction held, bus response (data_ok) still outstanding
//   ST_READY | instruction held and complete; buf_valid=1 if read data was
//            | captured while write-back was stalled
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   in_valid / in_ready     handshake with execute
//   ex_*                    instruction fields from execute
//   data_sram_data_ok/rdata bus response for the outstanding request
//   out_valid / out_ready   handshake with write-back
//   wb_*                    registered instruction fields to write-back
//   wb_rdata                raw read word (buffer if filled, else bus)
//   fwd_valid/dest/data     forwarding information for decode
//   load_block              load-use hazard indication for decode
// -----------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        resetn,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_result,
  input  logic [7:0]  ex_load_op,
  input  logic        ex_res_from_mem,
  input  logic        ex_gr_we,
  input  logic [4:0]  ex_dest,
  input  logic        ex_mem_req,

  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_result,
  output logic [7:0]  wb_load_op,
  output logic        wb_res_from_mem,
  output logic        wb_gr_we,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_rdata,

  output logic        fwd_valid,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_data,
  output logic        load_block
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        buf_valid;
  logic        buf_valid_nxt;
  logic        buf_load;
  logic [31:0] rdata_buf;

  logic        valid;
  logic        wait_resp;
  logic        ready_go;
  logic        accept;
  logic        drain;
  logic        dest_nz;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign valid     = (state != ST_EMPTY);
  assign wait_resp = (state == ST_WAIT);

  // data_ok only completes the instruction while a response is outstanding;
  // a stray pulse in any other state has no effect on anything.
  assign ready_go  = ~wait_resp | data_sram_data_ok;
  assign out_valid = valid & ready_go;
  assign in_ready  = ~valid | (ready_go & out_ready);

  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready & ~in_valid;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_EMPTY;
      buf_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      buf_valid <= buf_valid_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    buf_valid_nxt = buf_valid;
    buf_load      = 1'b0;

    if (accept) begin
      // Covers both a fill from empty and a drain-and-refill in one cycle.
      state_nxt     = ex_mem_req ? ST_WAIT : ST_READY;
      buf_valid_nxt = 1'b0;
    end else if (drain) begin
      state_nxt     = ST_EMPTY;
      buf_valid_nxt = 1'b0;
    end else if (wait_resp && data_sram_data_ok) begin
      // Reaching here means out_ready=0: the response has to be captured
      // because the bus only drives rdata during the data_ok cycle.
      state_nxt     = ST_READY;
      buf_valid_nxt = 1'b1;
      buf_load      = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_pc           <= 32'd0;
      wb_result       <= 32'd0;
      wb_load_op      <= 8'd0;
      wb_res_from_mem <= 1'b0;
      wb_gr_we        <= 1'b0;
      wb_dest         <= 5'd0;
    end else if (accept) begin
      wb_pc           <= ex_pc;
      wb_result       <= ex_result;
      wb_load_op      <= ex_load_op;
      wb_res_from_mem <= ex_res_from_mem;
      wb_gr_we        <= ex_gr_we;
      wb_dest         <= ex_dest;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_buf <= 32'd0;
    end else if (buf_load) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  assign wb_rdata = buf_valid ? rdata_buf : data_sram_rdata;

  // ---------------------------------------------------------------------------
  // Forwarding / hazard information (registered state only)
  // ---------------------------------------------------------------------------
  assign dest_nz    = (wb_dest != 5'd0);
  assign fwd_valid  = valid & wb_gr_we & dest_nz;
  assign fwd_dest   = wb_dest;
  assign fwd_data   = wb_result;
  assign load_block = valid & wb_res_from_mem & wb_gr_we & dest_nz;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_result;
  logic [7:0]  ex_load_op;
  logic        ex_res_from_mem;
  logic        ex_gr_we;
  logic [4:0]  ex_dest;
  logic        ex_mem_req;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] wb_pc;
  logic [31:0] wb_result;
  logic [7:0]  wb_load_op;
  logic        wb_res_from_mem;
  logic        wb_gr_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_rdata;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        load_block;

  int checks;
  int errors;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .ex_pc             (ex_pc),
    .ex_result         (ex_result),
    .ex_load_op        (ex_load_op),
    .ex_res_from_mem   (ex_res_from_mem),
    .ex_gr_we          (ex_gr_we),
    .ex_dest           (ex_dest),
    .ex_mem_req        (ex_mem_req),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .wb_pc             (wb_pc),
    .wb_result         (wb_result),
    .wb_load_op        (wb_load_op),
    .wb_res_from_mem   (wb_res_from_mem),
    .wb_gr_we          (wb_gr_we),
    .wb_dest           (wb_dest),
    .wb_rdata          (wb_rdata),
    .fwd_valid         (fwd_valid),
    .fwd_dest          (fwd_dest),
    .fwd_data          (fwd_data),
    .load_block        (load_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per cycle: inputs driven for that cycle, and the outputs
  // expected during it (before the next rising edge).
  typedef struct {
    logic        iv;
    logic        mr;
    logic        rm;
    logic        gw;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        dok;
    logic [31:0] rdata;
    logic        ordy;
    logic        e_in_ready;
    logic        e_out_valid;
    logic        e_fwd_valid;
    logic        e_load_block;
    logic [4:0]  e_dest;
    logic        chk_fields;
    logic [31:0] e_fwd_data;
    logic        chk_rdata;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //           iv mr rm gw dest result        dok rdata          ordy | ir ov fv lb dst chk fwd_data      chkr rdata
    vecs[0]  = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h0,         1,    1, 0, 0, 0, 5'd0, 0, 32'h0,        0, 32'h0};
    vecs[1]  = '{1, 0, 0, 1, 5'd5, 32'h42,       0, 32'h0,         1,    1, 0, 0, 0, 5'd0, 0, 32'h0,        0, 32'h0};
    vecs[2]  = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h0,         1,    1, 1, 1, 0, 5'd5, 1, 32'h42,       0, 32'h0};
    vecs[3]  = '{1, 1, 1, 1, 5'd7, 32'h100,      0, 32'h0,         1,    1, 0, 0, 0, 5'd0, 0, 32'h0,        0, 32'h0};
    vecs[4]  = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h0,         1,    0, 0, 1, 1, 5'd7, 1, 32'h100,      0, 32'h0};
    vecs[5]  = '{0, 0, 0, 0, 5'd0, 32'h0,        1, 32'hDEADBEEF,  1,    1, 1, 1, 1, 5'd7, 1, 32'h100,      1, 32'hDEADBEEF};
    vecs[6]  = '{1, 1, 1, 1, 5'd7, 32'h100,      0, 32'h0,         0,    1, 0, 0, 0, 5'd0, 0, 32'h0,        0, 32'h0};
    vecs[7]  = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h0,         0,    0, 0, 1, 1, 5'd7, 1, 32'h100,      0, 32'h0};
    vecs[8]  = '{0, 0, 0, 0, 5'd0, 32'h0,        1, 32'hDEADBEEF,  0,    0, 1, 1, 1, 5'd7, 1, 32'h100,      1, 32'hDEADBEEF};
    vecs[9]  = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h12345678,  0,    0, 1, 1, 1, 5'd7, 1, 32'h100,      1, 32'hDEADBEEF};
    vecs[10] = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h12345678,  1,    1, 1, 1, 1, 5'd7, 1, 32'h100,      1, 32'hDEADBEEF};
    vecs[11] = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h12345678,  1,    1, 0, 0, 0, 5'd0, 0, 32'h0,        1, 32'h12345678};
    vecs[12] = '{1, 0, 0, 1, 5'd1, 32'h1,        0, 32'h0,         1,    1, 0, 0, 0, 5'd0, 0, 32'h0,        0, 32'h0};
    vecs[13] = '{1, 0, 0, 1, 5'd2, 32'h2,        0, 32'h0,         1,    1, 1, 1, 0, 5'd1, 1, 32'h1,        0, 32'h0};
    vecs[14] = '{1, 0, 0, 1, 5'd3, 32'h3,        0, 32'h0,         1,    1, 1, 1, 0, 5'd2, 1, 32'h2,        0, 32'h0};
    vecs[15] = '{1, 0, 0, 1, 5'd4, 32'h4,        0, 32'h0,         1,    1, 1, 1, 0, 5'd3, 1, 32'h3,        0, 32'h0};
    vecs[16] = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h0,         1,    1, 1, 1, 0, 5'd4, 1, 32'h4,        0, 32'h0};
    vecs[17] = '{1, 0, 0, 1, 5'd0, 32'h55,       0, 32'h0,         0,    1, 0, 0, 0, 5'd0, 0, 32'h0,        0, 32'h0};
    vecs[18] = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h0,         0,    0, 1, 0, 0, 5'd0, 1, 32'h55,       0, 32'h0};
    vecs[19] = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h0,         1,    1, 1, 0, 0, 5'd0, 1, 32'h55,       0, 32'h0};
    vecs[20] = '{1, 0, 0, 1, 5'd9, 32'h99,       0, 32'h0,         0,    1, 0, 0, 0, 5'd0, 0, 32'h0,        0, 32'h0};
    vecs[21] = '{0, 0, 0, 0, 5'd0, 32'h0,        1, 32'h00000BAD,  0,    0, 1, 1, 0, 5'd9, 1, 32'h99,       1, 32'h00000BAD};
    vecs[22] = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h0,         1,    1, 1, 1, 0, 5'd9, 1, 32'h99,       1, 32'h0};
    vecs[23] = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h0,         1,    1, 0, 0, 0, 5'd0, 0, 32'h0,        0, 32'h0};
    vecs[24] = '{1, 1, 0, 0, 5'd3, 32'h200,      0, 32'h0,         1,    1, 0, 0, 0, 5'd0, 0, 32'h0,        0, 32'h0};
    vecs[25] = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h0,         1,    0, 0, 0, 0, 5'd3, 1, 32'h200,      0, 32'h0};
    vecs[26] = '{0, 0, 0, 0, 5'd0, 32'h0,        1, 32'h0000CAFE,  1,    1, 1, 0, 0, 5'd3, 1, 32'h200,      0, 32'h0};
    vecs[27] = '{0, 0, 0, 0, 5'd0, 32'h0,        0, 32'h0,         1,    1, 0, 0, 0, 5'd0, 0, 32'h0,        0, 32'h0};
  end

  initial begin
    checks = 0;
    errors = 0;
    resetn            = 1'b0;
    in_valid          = 1'b0;
    ex_pc             = 32'h0;
    ex_result         = 32'h0;
    ex_load_op        = 8'h0;
    ex_res_from_mem   = 1'b0;
    ex_gr_we          = 1'b0;
    ex_dest           = 5'd0;
    ex_mem_req        = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    out_ready         = 1'b1;

    #1;
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("rst.load_block", {31'd0, load_block}, 32'd0);
    check("rst.wb_pc", wb_pc, 32'd0);

    #11 resetn = 1'b1;
    @(posedge clk); #1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NV; i++) begin
      in_valid          = vecs[i].iv;
      ex_mem_req        = vecs[i].mr;
      ex_res_from_mem   = vecs[i].rm;
      ex_gr_we          = vecs[i].gw;
      ex_dest           = vecs[i].dest;
      ex_result         = vecs[i].result;
      ex_pc             = 32'h1000 + 32'(i * 4);
      ex_load_op        = 8'h01;
      data_sram_data_ok = vecs[i].dok;
      data_sram_rdata   = vecs[i].rdata;
      out_ready         = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_in_ready});
      check($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_out_valid});
      check($sformatf("v%0d.fwd_valid", i), {31'd0, fwd_valid}, {31'd0, vecs[i].e_fwd_valid});
      check($sformatf("v%0d.load_block", i), {31'd0, load_block}, {31'd0, vecs[i].e_load_block});
      if (vecs[i].chk_fields) begin
        check($sformatf("v%0d.wb_dest", i), {27'd0, wb_dest}, {27'd0, vecs[i].e_dest});
        check($sformatf("v%0d.fwd_dest", i), {27'd0, fwd_dest}, {27'd0, vecs[i].e_dest});
        check($sformatf("v%0d.fwd_data", i), fwd_data, vecs[i].e_fwd_data);
        check($sformatf("v%0d.wb_result", i), wb_result, vecs[i].e_fwd_data);
      end
      if (vecs[i].chk_rdata)
        check($sformatf("v%0d.wb_rdata", i), wb_rdata, vecs[i].e_rdata);
      @(posedge clk); #1;
    end

    // ---------------- reset while waiting for data_ok ----------------
    in_valid          = 1'b1;
    ex_pc             = 32'h8000_0010;
    ex_result         = 32'h300;
    ex_load_op        = 8'h04;
    ex_res_from_mem   = 1'b1;
    ex_gr_we          = 1'b1;
    ex_dest           = 5'd12;
    ex_mem_req        = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    out_ready         = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    check("wait.wb_pc", wb_pc, 32'h8000_0010);
    check("wait.wb_load_op", {24'd0, wb_load_op}, 32'h04);
    check("wait.wb_res_from_mem", {31'd0, wb_res_from_mem}, 32'd1);
    check("wait.wb_gr_we", {31'd0, wb_gr_we}, 32'd1);
    check("wait.out_valid", {31'd0, out_valid}, 32'd0);
    check("wait.load_block", {31'd0, load_block}, 32'd1);
    resetn = 1'b0;
    #1;
    check("rstwait.out_valid", {31'd0, out_valid}, 32'd0);
    check("rstwait.in_ready", {31'd0, in_ready}, 32'd1);
    check("rstwait.fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("rstwait.load_block", {31'd0, load_block}, 32'd0);
    check("rstwait.wb_pc", wb_pc, 32'd0);
    check("rstwait.wb_dest", {27'd0, wb_dest}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h777;
    #1;
    check("late_ok.out_valid", {31'd0, out_valid}, 32'd0);
    check("late_ok.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    #1;
    check("after_ok.out_valid", {31'd0, out_valid}, 32'd0);
    check("after_ok.load_block", {31'd0, load_block}, 32'd0);

    // ---------------- bounded-latency load ----------------
    // data_ok arrives three cycles after entry; out_valid must rise exactly then.
    in_valid        = 1'b1;
    ex_mem_req      = 1'b1;
    ex_res_from_mem = 1'b1;
    ex_gr_we        = 1'b1;
    ex_dest         = 5'd20;
    ex_result       = 32'h400;
    out_ready       = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    begin
      int lat;
      lat = -1;
      for (int c = 1; c <= 10; c++) begin
        data_sram_data_ok = (c == 3);
        data_sram_rdata   = (c == 3) ? 32'hA5A5_0003 : 32'h0;
        @(negedge clk);
        if (out_valid && lat < 0) begin
          lat = c;
          check("lat.wb_rdata", wb_rdata, 32'hA5A5_0003);
        end
        @(posedge clk); #1;
        if (lat >= 0) break;
      end
      data_sram_data_ok = 1'b0;
      check("lat.cycles", lat, 32'd3);
    end
    @(negedge clk);
    check("lat.drained", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
